cic_interpolator: RTL and testbench
===================================

# cic_interpolator

Cascaded integrator-comb interpolator that raises a low-rate signed sample stream by an integer factor RATE. It is the upsampling counterpart of the moving-average/boxcar decimation path: it sits between the low-rate processing chain and the DAC path. It accepts one sample per RATE clocks through a valid/ready handshake and emits one filtered sample every clock. All arithmetic is two's complement, and the internal registers wrap modulo their width.

## Interface
- INPUT_WIDTH, 16, signed input sample width
- RATE, 4, interpolation factor; power of two, at least 2
- STAGES, 2, number of comb stages and number of integrator stages (1..6)
- LOG2_RATE, derived: log2(RATE)
- OUTPUT_WIDTH, derived: INPUT_WIDTH + STAGES*LOG2_RATE
- clk  in  1  clock
- rst_active_low  in  1  asynchronous, active-low reset; clears all state
- data_in  in  INPUT_WIDTH  signed low-rate sample
- in_valid  in  1  data_in is valid
- in_ready  out  1  the block accepts data_in on this cycle
- full_out  out  OUTPUT_WIDTH  signed full-precision integrator output
- data_out  out  INPUT_WIDTH  full_out arithmetically shifted right by (STAGES-1)*LOG2_RATE, then truncated to INPUT_WIDTH
- out_valid  out  1  full_out and data_out carry a valid sample
- underrun  out  1  one-cycle pulse when a sample slot passes without input

## Operation
- State machine:
  - IDLE (the reset state): phase counter holds 0; in_ready = 1.
  - An accept (in_valid & in_ready) moves IDLE -> RUN.
  - RUN: the phase counter counts 0..RATE-1 and wraps; in_ready = (phase == 0).
  - RUN never returns to IDLE; only reset leaves RUN.
- Slot cycle: the phase-0 cycle in RUN, or the accepting cycle in IDLE.
  - The comb chain samples x = data_in if in_valid, else x = 0.
  - A missed slot (in_valid = 0 at phase 0 in RUN) pulses underrun and inserts a zero. The phase does not stall.
- Comb chain:
  - Combinational chain of STAGES stages: y_k = y_(k-1) - d_k.
  - Each d_k updates to y_(k-1) on slot cycles only.
  - The result is registered into comb_reg on slot cycles. Width is OUTPUT_WIDTH with sign extension.
- Zero-stuffing: the upsampled value u equals comb_reg on the cycle after a slot, and 0 otherwise. A registered flag selects between them.
- Integrators:
  - i_1 <= i_1 + u; i_k <= i_k + i_(k-1) for k > 1.
  - Every integrator updates every cycle in RUN and wraps.
- Outputs:
  - full_out = i_STAGES.
  - DC gain of full_out is RATE^(STAGES-1); data_out removes this gain.
- out_valid:
  - Goes high STAGES+1 cycles after the first accept.
  - Then stays high every cycle until reset.
- Reset (asynchronous, at any time, including mid-operation): every register goes to 0, the state goes to IDLE, and in_ready goes low while reset is asserted.
- Output values during reset and in IDLE: full_out = 0, data_out = 0, out_valid = 0, underrun = 0.

## Timing
- An accept at clock edge t updates comb_reg at t+1 and i_1 at t+2. It first affects full_out after edge t+1+STAGES.
- Steady-state throughput: one input per RATE clocks; one output per clock.
- in_ready in RUN is high exactly one cycle in every RATE. Holding in_valid high gives back-to-back accepts RATE cycles apart.
- Simultaneous in_valid and reset release: the sample is not accepted on the release edge. The first possible accept is the following edge.
- underrun asserts in the same cycle as the missed phase-0 slot.

## Structure
- Shared package cic_pkg:
  - clog2 function.
  - Width derivation for OUTPUT_WIDTH.
  - State encoding localparams IDLE/RUN.
- Natural sub-module: cic_integrator_stage (parameter WIDTH).
  - Accumulator with enable and async reset, instantiated STAGES times by generate.
  - The comb chain stays inline.

## Test plan
- Reset check (STAGES=2, RATE=4): hold reset 5 cycles with in_valid=1 -> in_ready=0, out_valid=0, full_out=0; after release in_ready=1 in IDLE.
- Impulse: accept 100, then zeros every slot -> full_out = 100,200,300,400,300,200,100,0; data_out = 25,50,75,100,75,50,25,0; first nonzero value 3 edges after the accept.
- Step: accept 1 every slot -> full_out = 1,2,3,4,4,4...; data_out settles to 1; in_ready high exactly every 4th cycle.
- Negative full scale: continuous -32768 -> full_out settles to -131072; data_out = -32768; no wrap glitch in the output.
- Underrun: drop in_valid for one slot while in RUN -> one-cycle underrun pulse at that phase-0 cycle; output matches a zero-sample reference model; phase stays unshifted.
- Mid-stream reset: assert reset during phase 2 -> all outputs 0 immediately (asynchronous); after release, behaviour matches the impulse test from IDLE.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared constants, width helpers and state encoding for the CIC interpolator.
package cic_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int cic_out_width(input int in_w, input int stages, input int rate);
        return in_w + stages * clog2(rate);
    endfunction

    localparam logic IDLE_ENC = 1'b0;
    localparam logic RUN_ENC  = 1'b1;

    typedef enum logic {
        IDLE = IDLE_ENC,
        RUN  = RUN_ENC
    } state_e;

endpackage

// File: rtl/cic_integrator_stage.sv
// Wrapping accumulator: acc <= acc + din while enabled; one register of latency,
// no backpressure (advances whenever en_i is high).
module cic_integrator_stage #(
    parameter int WIDTH = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic signed [WIDTH-1:0] din_i,
    output logic signed [WIDTH-1:0] acc_o
);

    logic signed [WIDTH-1:0] acc_q;
    logic signed [WIDTH-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = acc_q + din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator by RATE: accept takes STAGES+1 edges to reach full_out, one output per clock.
// Backpressure: in_ready is high only on the phase-0 slot; an empty slot inserts zero and pulses underrun.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter  int INPUT_WIDTH  = 16,
    parameter  int RATE         = 4,
    parameter  int STAGES       = 2,
    localparam int LOG2_RATE    = clog2(RATE),
    localparam int OUTPUT_WIDTH = cic_out_width(INPUT_WIDTH, STAGES, RATE)
) (
    input  logic                           clk,
    input  logic                           rst_active_low,
    input  logic signed [INPUT_WIDTH-1:0]  data_in,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [OUTPUT_WIDTH-1:0] full_out,
    output logic signed [INPUT_WIDTH-1:0]  data_out,
    output logic                           out_valid,
    output logic                           underrun
);

    localparam int SHIFT = (STAGES - 1) * LOG2_RATE;

    state_e                         state_q, state_d;
    logic [LOG2_RATE-1:0]           phase_q, phase_d;
    logic                           rdy_en_q;
    logic                           stuff_q;
    logic [STAGES:0]                vld_sr_q;
    logic signed [OUTPUT_WIDTH-1:0] comb_q;
    logic signed [OUTPUT_WIDTH-1:0] dly_q [STAGES];
    logic signed [OUTPUT_WIDTH-1:0] y     [STAGES+1];
    logic signed [OUTPUT_WIDTH-1:0] integ [STAGES+1];
    logic                           slot;
    logic                           run;

    // rdy_en_q keeps in_ready low until the first edge after reset release.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        in_ready = 1'b0;
        slot     = 1'b0;
        underrun = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = rdy_en_q;
                if (in_valid && rdy_en_q) begin
                    state_d = RUN;
                    phase_d = LOG2_RATE'(1);
                    slot    = 1'b1;
                end
            end
            RUN: begin
                slot     = (phase_q == '0);
                in_ready = slot;
                underrun = slot && !in_valid;
                phase_d  = phase_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign run  = (state_q == RUN);
    assign y[0] = in_valid ? OUTPUT_WIDTH'(data_in) : '0;

    for (genvar k = 1; k <= STAGES; k++) begin : g_comb
        assign y[k] = y[k-1] - dly_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            rdy_en_q <= 1'b0;
            stuff_q  <= 1'b0;
            vld_sr_q <= '0;
            comb_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dly_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            rdy_en_q <= 1'b1;
            stuff_q  <= slot;
            vld_sr_q <= {vld_sr_q[STAGES-1:0], (state_d == RUN)};
            if (slot) begin
                comb_q <= y[STAGES];
                for (int k = 0; k < STAGES; k++) begin
                    dly_q[k] <= y[k];
                end
            end
        end
    end

    // Zero-stuffing: the comb result is presented for one cycle after each slot.
    assign integ[0] = stuff_q ? comb_q : '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_integ
        cic_integrator_stage #(
            .WIDTH(OUTPUT_WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_active_low),
            .en_i  (run),
            .din_i (integ[k]),
            .acc_o (integ[k+1])
        );
    end

    assign full_out  = integ[STAGES];
    assign data_out  = INPUT_WIDTH'(full_out >>> SHIFT);
    assign out_valid = vld_sr_q[STAGES];

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator: convolution reference model feeding a scoreboard queue.
module tb_cic_interpolator;

    localparam int IW     = 16;
    localparam int RATE   = 4;
    localparam int STAGES = 2;
    localparam int LR     = $clog2(RATE);
    localparam int OW     = IW + STAGES * LR;
    localparam int SHIFT  = (STAGES - 1) * LR;
    localparam int HLEN   = STAGES * (RATE - 1) + 1;

    logic                 clk;
    logic                 rst_active_low;
    logic signed [IW-1:0] data_in;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [OW-1:0] full_out;
    logic signed [IW-1:0] data_out;
    logic                 out_valid;
    logic                 underrun;

    cic_interpolator #(
        .INPUT_WIDTH (IW),
        .RATE        (RATE),
        .STAGES      (STAGES)
    ) dut (
        .clk            (clk),
        .rst_active_low (rst_active_low),
        .data_in        (data_in),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .full_out       (full_out),
        .data_out       (data_out),
        .out_valid      (out_valid),
        .underrun       (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [OW-1:0] full;
        logic signed [IW-1:0] dat;
    } exp_t;

    int                   checks = 0;
    int                   errors = 0;
    longint               h [HLEN];
    longint               hist [$];
    exp_t                 sb [$];
    logic signed [OW-1:0] obs_f [$];
    logic signed [IW-1:0] obs_d [$];
    bit                   m_run, m_rdy_en;
    int                   m_phase, m_edges, m_slots;

    longint imp_full [8] = '{100, 200, 300, 400, 300, 200, 100, 0};
    longint imp_data [8] = '{25, 50, 75, 100, 75, 50, 25, 0};

    task automatic check(input string tag, input logic signed [63:0] act_v,
                         input logic signed [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act_v, exp_v, $time);
        end
    endtask

    task automatic model_clear();
        m_run    = 1'b0;
        m_rdy_en = 1'b0;
        m_phase  = 0;
        m_edges  = 0;
        m_slots  = 0;
        hist.delete();
        sb.delete();
        obs_f.delete();
        obs_d.delete();
    endtask

    // One clock: drive, predict, compare at negedge, advance the model at posedge.
    task automatic cycle(input bit v, input logic signed [IW-1:0] d);
        bit     exp_rdy, slot, exp_vld;
        longint u, y;
        exp_t   e;
        in_valid = v;
        data_in  = d;
        @(negedge clk);
        exp_rdy = m_rdy_en && (!m_run || m_phase == 0);
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("underrun", 64'(underrun), 64'(m_run && m_phase == 0 && !v));
        slot = m_run ? (m_phase == 0) : (v && exp_rdy);
        if (m_run || slot) begin
            u = (slot && v) ? longint'(d) : 64'sd0;
            hist.push_front(u);
            if (hist.size() > HLEN) void'(hist.pop_back());
            y = 0;
            for (int k = 0; k < hist.size(); k++) y += h[k] * hist[k];
            e.full = OW'(y);
            e.dat  = IW'(e.full >>> SHIFT);
            sb.push_back(e);
        end
        exp_vld = (m_edges > STAGES);
        check("out_valid", 64'(out_valid), 64'(exp_vld));
        if (exp_vld && sb.size() > 0) begin
            e = sb.pop_front();
            check("full_out", 64'(full_out), 64'(e.full));
            check("data_out", 64'(data_out), 64'(e.dat));
            obs_f.push_back(full_out);
            obs_d.push_back(data_out);
        end else if (!exp_vld) begin
            check("full_quiet", 64'(full_out), 64'sd0);
            check("data_quiet", 64'(data_out), 64'sd0);
        end
        @(posedge clk);
        if (!m_run && slot) begin
            m_run   = 1'b1;
            m_phase = 1;
        end else if (m_run) begin
            m_phase = (m_phase + 1) % RATE;
        end
        if (m_run) m_edges++;
        if (slot) m_slots++;
        m_rdy_en = 1'b1;
        #1;
    endtask

    task automatic reset_cycles(input int n);
        rst_active_low = 1'b0;
        in_valid       = 1'b1;
        data_in        = 16'sd123;
        model_clear();
        repeat (n) begin
            @(negedge clk);
            check("rst_in_ready", 64'(in_ready), 64'sd0);
            check("rst_out_valid", 64'(out_valid), 64'sd0);
            check("rst_full_out", 64'(full_out), 64'sd0);
            check("rst_underrun", 64'(underrun), 64'sd0);
            @(posedge clk);
            #1;
        end
        rst_active_low = 1'b1;
    endtask

    task automatic run_impulse();
        cycle(1'b1, 16'sd77);
        cycle(1'b0, 16'sd0);
        for (int i = 0; i < 16; i++) cycle(1'b1, (m_slots == 0) ? 16'sd100 : 16'sd0);
        for (int i = 0; i < 8; i++) begin
            if (i < obs_f.size()) begin
                check("imp_full_tbl", 64'(obs_f[i]), imp_full[i]);
                check("imp_data_tbl", 64'(obs_d[i]), imp_data[i]);
            end else begin
                check("imp_count", 64'(obs_f.size()), 64'(i + 1));
            end
        end
    endtask

    initial begin
        longint tmp [HLEN];
        int     s0;
        for (int i = 0; i < HLEN; i++) h[i] = 0;
        h[0] = 1;
        for (int s = 0; s < STAGES; s++) begin
            for (int i = 0; i < HLEN; i++) tmp[i] = 0;
            for (int i = 0; i < HLEN; i++)
                for (int j = 0; j < RATE; j++)
                    if (i + j < HLEN) tmp[i+j] += h[i];
            for (int i = 0; i < HLEN; i++) h[i] = tmp[i];
        end

        rst_active_low = 1'b0;
        in_valid       = 1'b1;
        data_in        = 16'sd0;
        reset_cycles(5);

        // Impulse from IDLE; the first cycle after release must not accept.
        run_impulse();

        obs_f.delete();
        obs_d.delete();
        for (int i = 0; i < 24; i++) cycle(1'b1, 16'sd1);
        check("step_full", 64'(obs_f[obs_f.size()-1]), 64'sd4);
        check("step_data", 64'(obs_d[obs_d.size()-1]), 64'sd1);

        obs_f.delete();
        obs_d.delete();
        for (int i = 0; i < 28; i++) cycle(1'b1, 16'sh8000);
        check("negfs_full", 64'(obs_f[obs_f.size()-1]), -64'sd131072);
        check("negfs_data", 64'(obs_d[obs_d.size()-1]), -64'sd32768);

        s0 = m_slots;
        for (int i = 0; i < 24; i++)
            cycle(!(m_run && m_phase == 0 && m_slots == s0 + 3), 16'sd500);

        // Asynchronous reset in the middle of an impulse response, at phase 2.
        reset_cycles(2);
        run_impulse();
        for (int i = 0; i < 16; i++) begin
            if (m_edges >= 6 && m_phase == 2) break;
            cycle(1'b1, 16'sd0);
        end
        check("mid_phase", 64'(m_phase), 64'sd2);
        cycle(1'b1, 16'sd100);
        while (m_phase != 2 && m_edges < 200) cycle(1'b1, 16'sd100);
        rst_active_low = 1'b0;
        #1;
        check("async_full", 64'(full_out), 64'sd0);
        check("async_data", 64'(data_out), 64'sd0);
        check("async_valid", 64'(out_valid), 64'sd0);
        check("async_ready", 64'(in_ready), 64'sd0);
        check("async_under", 64'(underrun), 64'sd0);
        @(posedge clk);
        #1;
        reset_cycles(3);
        run_impulse();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
